// File: rtl/text_exec_engine_pkg.sv
// Shared text/pixel engine definitions: opcodes, VRAM cell layout, FSM states.
// Included by the text execution engine and its cursor sub-block.
package vga_pkg;

  typedef enum logic [7:0] {
    OP_TEXT_WRITE    = 8'h00,
    OP_TEXT_POSITION = 8'h01,
    OP_TEXT_CLEAR    = 8'h02,
    OP_GET_TEXT_AT   = 8'h03,
    OP_PIXEL_10      = 8'h10,
    OP_PIXEL_11      = 8'h11,
    OP_PIXEL_12      = 8'h12,
    OP_PIXEL_13      = 8'h13,
    OP_PIXEL_14      = 8'h14
  } opcode_t;

  typedef struct packed {
    logic [7:0] attr;
    logic [7:0] chr;
  } cell_t;

  localparam logic [7:0] BLANK_CHAR   = 8'h20;
  localparam logic [7:0] NEWLINE_CHAR = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_WRITE,
    S_CLEAR,
    S_READ,
    S_DONE
  } state_t;

  function automatic logic [31:0] cell_index(input logic [31:0] col,
                                             input logic [31:0] row,
                                             input logic [31:0] cols);
    return row * cols + col;
  endfunction

  function automatic logic is_text_op(input logic [7:0] op);
    return op inside {OP_TEXT_WRITE, OP_TEXT_POSITION, OP_TEXT_CLEAR, OP_GET_TEXT_AT};
  endfunction

endpackage

// File: rtl/text_exec_engine_if.sv
// CPU-instruction and VRAM req/ack signal bundle for the text execution engine.
// slave = engine side, master = CPU interface / VRAM arbiter side.
interface text_exec_engine_if #(parameter int ADDR_W = 12);

  logic [7:0]        instruction;
  logic [7:0]        arg0;
  logic [7:0]        arg1;
  logic              instruction_start;
  logic              instruction_busy;
  logic              instruction_finished;
  logic              instruction_error;
  logic [7:0]        result_0;
  logic [7:0]        result_1;
  logic              vram_req;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [15:0]       vram_wdata;
  logic [15:0]       vram_rdata;
  logic              vram_ack;

  modport slave (
    input  instruction, arg0, arg1, instruction_start, vram_rdata, vram_ack,
    output instruction_busy, instruction_finished, instruction_error,
           result_0, result_1, vram_req, vram_we, vram_addr, vram_wdata
  );

  modport master (
    output instruction, arg0, arg1, instruction_start, vram_rdata, vram_ack,
    input  instruction_busy, instruction_finished, instruction_error,
           result_0, result_1, vram_req, vram_we, vram_addr, vram_wdata
  );

endinterface

// File: rtl/text_exec_engine_text_cursor.sv
// Text cursor: set, advance-with-wrap and newline; emits row*COLS+col.
// Updates take effect on the next clock; no backpressure.
module text_cursor
  import vga_pkg::*;
#(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12,
  parameter int COL_W  = $clog2(COLS),
  parameter int ROW_W  = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_set,
  input  logic [COL_W-1:0]  i_set_col,
  input  logic [ROW_W-1:0]  i_set_row,
  input  logic              i_advance,
  input  logic              i_newline,
  output logic [ADDR_W-1:0] o_addr
);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [ROW_W-1:0] w_row_next;

  // No scrolling: the last row wraps back to the top.
  assign w_row_next = (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + ROW_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_set) begin
      r_col <= i_set_col;
      r_row <= i_set_row;
    end else if (i_advance) begin
      if (r_col == COL_W'(COLS - 1)) begin
        r_col <= '0;
        r_row <= w_row_next;
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end else if (i_newline) begin
      r_col <= '0;
      r_row <= w_row_next;
    end
  end

  assign o_addr = ADDR_W'(cell_index(32'(r_col), 32'(r_row), 32'(COLS)));

endmodule

// File: rtl/text_exec_engine.sv
// Executes text opcodes $00-$03 against character VRAM over a req/ack port.
// Start->finished is 2 cycles plus ack wait per VRAM access; starts while busy are ignored.
module text_exec_engine
  import vga_pkg::*;
#(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic               phi2,
  input  logic               reset,
  text_exec_engine_if.slave  bus
);

  localparam int                COL_W     = $clog2(COLS);
  localparam int                ROW_W     = $clog2(ROWS);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_op;
  logic [7:0]        r_arg0;
  logic [7:0]        r_arg1;
  logic              r_error;
  logic [7:0]        r_result_0;
  logic [7:0]        r_result_1;
  logic [ADDR_W-1:0] r_clr_cnt;

  logic              w_accept;
  logic              w_new_ok;
  logic              w_args_ok;
  logic              w_clr_last;
  logic              w_cur_set;
  logic              w_cur_adv;
  logic              w_cur_nl;
  logic [COL_W-1:0]  w_set_col;
  logic [ROW_W-1:0]  w_set_row;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [ADDR_W-1:0] w_arg_addr;
  cell_t             w_rcell;
  logic              w_vram_req;
  logic              w_vram_we;
  logic [ADDR_W-1:0] w_vram_addr;
  logic [15:0]       w_vram_wdata;

  assign w_accept   = (r_state == S_IDLE) && bus.instruction_start && is_text_op(bus.instruction);
  assign w_new_ok   = (32'(bus.arg0) < 32'(COLS)) && (32'(bus.arg1) < 32'(ROWS));
  assign w_args_ok  = (32'(r_arg0) < 32'(COLS)) && (32'(r_arg1) < 32'(ROWS));
  assign w_clr_last = (r_clr_cnt == LAST_CELL);
  assign w_arg_addr = ADDR_W'(cell_index(32'(r_arg0), 32'(r_arg1), 32'(COLS)));
  assign w_rcell    = cell_t'(bus.vram_rdata);

  always_ff @(posedge phi2 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Newline writes and rejected GET_TEXT_AT go through EXEC so every op sees busy before finished.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.instruction)
            OP_TEXT_WRITE:  w_next = (bus.arg1 == NEWLINE_CHAR) ? S_EXEC : S_WRITE;
            OP_TEXT_CLEAR:  w_next = S_CLEAR;
            OP_GET_TEXT_AT: w_next = w_new_ok ? S_READ : S_EXEC;
            default:        w_next = S_EXEC;
          endcase
        end
      end
      S_EXEC:          w_next = S_DONE;
      S_WRITE, S_READ: if (bus.vram_ack) w_next = S_DONE;
      S_CLEAR:         if (bus.vram_ack && w_clr_last) w_next = S_DONE;
      S_DONE:          w_next = S_IDLE;
      default:         w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge phi2 or posedge reset) begin
    if (reset) begin
      r_op       <= '0;
      r_arg0     <= '0;
      r_arg1     <= '0;
      r_error    <= 1'b0;
      r_result_0 <= '0;
      r_result_1 <= '0;
      r_clr_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_op      <= bus.instruction;
        r_arg0    <= bus.arg0;
        r_arg1    <= bus.arg1;
        r_error   <= 1'b0;
        r_clr_cnt <= '0;
      end
      if (r_state == S_EXEC)
        r_error <= (r_op != OP_TEXT_WRITE) && !w_args_ok;
      if (r_state == S_READ && bus.vram_ack) begin
        r_result_0 <= w_rcell.chr;
        r_result_1 <= w_rcell.attr;
      end
      if (r_state == S_CLEAR && bus.vram_ack && !w_clr_last)
        r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
    end
  end

  assign w_cur_set = ((r_state == S_EXEC) && (r_op == OP_TEXT_POSITION) && w_args_ok) ||
                     ((r_state == S_CLEAR) && bus.vram_ack && w_clr_last);
  assign w_set_col = (r_state == S_CLEAR) ? '0 : COL_W'(r_arg0);
  assign w_set_row = (r_state == S_CLEAR) ? '0 : ROW_W'(r_arg1);
  assign w_cur_adv = (r_state == S_WRITE) && bus.vram_ack;
  assign w_cur_nl  = (r_state == S_EXEC) && (r_op == OP_TEXT_WRITE);

  text_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W)
  ) u_cursor (
    .clk       (phi2),
    .rst       (reset),
    .i_set     (w_cur_set),
    .i_set_col (w_set_col),
    .i_set_row (w_set_row),
    .i_advance (w_cur_adv),
    .i_newline (w_cur_nl),
    .o_addr    (w_cur_addr)
  );

  // VRAM port is a pure function of state and latched operands, so it holds steady until ack.
  always_comb begin
    w_vram_req   = 1'b0;
    w_vram_we    = 1'b0;
    w_vram_addr  = '0;
    w_vram_wdata = '0;
    case (r_state)
      S_WRITE: begin
        w_vram_req   = 1'b1;
        w_vram_we    = 1'b1;
        w_vram_addr  = w_cur_addr;
        w_vram_wdata = {r_arg0, r_arg1};
      end
      S_CLEAR: begin
        w_vram_req   = 1'b1;
        w_vram_we    = 1'b1;
        w_vram_addr  = r_clr_cnt;
        w_vram_wdata = {r_arg0, BLANK_CHAR};
      end
      S_READ: begin
        w_vram_req   = 1'b1;
        w_vram_addr  = w_arg_addr;
      end
      default: ;
    endcase
  end

  assign bus.vram_req             = w_vram_req;
  assign bus.vram_we              = w_vram_we;
  assign bus.vram_addr            = w_vram_addr;
  assign bus.vram_wdata           = w_vram_wdata;
  assign bus.instruction_busy     = (r_state == S_EXEC) || (r_state == S_WRITE) ||
                                    (r_state == S_CLEAR) || (r_state == S_READ);
  assign bus.instruction_finished = (r_state == S_DONE);
  assign bus.instruction_error    = r_error;
  assign bus.result_0             = r_result_0;
  assign bus.result_1             = r_result_1;

endmodule

// File: tb/tb_text_exec_engine.sv
// Scoreboard bench: stimulus pushes expected VRAM accesses and completions; a VRAM responder pops them.
module tb_text_exec_engine;
  import vga_pkg::*;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int NCELL = COLS * ROWS;

  logic phi2  = 1'b0;
  logic reset = 1'b1;
  always #5 phi2 = ~phi2;

  text_exec_engine_if #(.ADDR_W(12)) bus();

  text_exec_engine #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(12)) dut (
    .phi2  (phi2),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {logic we; logic [11:0] addr; logic [15:0] wdata;} acc_t;
  typedef struct {logic err; logic [7:0] r0; logic [7:0] r1;} res_t;

  acc_t        exp_acc[$];
  res_t        exp_res[$];
  logic [15:0] vmem[NCELL];
  logic [15:0] exp_mem[NCELL];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  int          max_dly  = 0;
  int          mcol     = 0;
  int          mrow     = 0;
  logic [7:0]  mr0      = 8'h00;
  logic [7:0]  mr1      = 8'h00;
  int          base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model of the cursor, result registers and screen contents.
  task automatic model(input logic [7:0] op, input logic [7:0] a0, input logic [7:0] a1);
    logic err;
    int   addr;
    err = 1'b0;
    case (op)
      8'h00: begin
        if (a1 == 8'h0A) begin
          mcol = 0;
          mrow = (mrow + 1) % ROWS;
        end else begin
          addr = mrow * COLS + mcol;
          exp_acc.push_back('{1'b1, 12'(addr), {a0, a1}});
          exp_mem[addr] = {a0, a1};
          mcol++;
          if (mcol == COLS) begin
            mcol = 0;
            mrow = (mrow + 1) % ROWS;
          end
        end
        exp_res.push_back('{1'b0, mr0, mr1});
      end
      8'h01: begin
        err = (int'(a0) >= COLS) || (int'(a1) >= ROWS);
        if (!err) begin
          mcol = int'(a0);
          mrow = int'(a1);
        end
        exp_res.push_back('{err, mr0, mr1});
      end
      8'h02: begin
        for (int i = 0; i < NCELL; i++) begin
          exp_acc.push_back('{1'b1, 12'(i), {a0, 8'h20}});
          exp_mem[i] = {a0, 8'h20};
        end
        mcol = 0;
        mrow = 0;
        exp_res.push_back('{1'b0, mr0, mr1});
      end
      8'h03: begin
        err = (int'(a0) >= COLS) || (int'(a1) >= ROWS);
        if (!err) begin
          addr = int'(a1) * COLS + int'(a0);
          exp_acc.push_back('{1'b0, 12'(addr), 16'h0000});
          mr0 = exp_mem[addr][7:0];
          mr1 = exp_mem[addr][15:8];
        end
        exp_res.push_back('{err, mr0, mr1});
      end
      default: ;
    endcase
  endtask

  task automatic issue(input logic [7:0] op, input logic [7:0] a0, input logic [7:0] a1,
                       input bit wait_done, input int exp_lat);
    int lat;
    bit text;
    text = (op <= 8'h03);
    @(negedge phi2);
    model(op, a0, a1);
    bus.instruction       = op;
    bus.arg0              = a0;
    bus.arg1              = a1;
    bus.instruction_start = 1'b1;
    @(negedge phi2);
    bus.instruction_start = 1'b0;
    check("busy_after_start", bus.instruction_busy, text);
    if (!wait_done || !text) return;
    lat = 1;
    while (!bus.instruction_finished && lat < 30000) begin
      @(negedge phi2);
      lat++;
    end
    check("finished_seen", bus.instruction_finished, 1);
    if (exp_lat > 0) check("latency", lat, exp_lat);
  endtask

  // VRAM responder and completion scoreboard.
  initial begin : responder
    acc_t a;
    int   cnt;
    bit   in_acc;
    res_t r;
    in_acc = 1'b0;
    cnt    = 0;
    bus.vram_ack   = 1'b0;
    bus.vram_rdata = 16'h0000;
    forever begin
      @(negedge phi2);
      bus.vram_ack = 1'b0;
      if (reset) begin
        in_acc = 1'b0;
        continue;
      end
      if (bus.instruction_finished) begin
        if (exp_res.size() == 0) begin
          check("finished_expected", 0, 1);
        end else begin
          r = exp_res.pop_front();
          check("finished_busy_low", bus.instruction_busy, 0);
          check("error", bus.instruction_error, r.err);
          check("result_0", bus.result_0, r.r0);
          check("result_1", bus.result_1, r.r1);
        end
      end
      if (bus.vram_req) begin
        if (!in_acc) begin
          n_acc++;
          if (exp_acc.size() == 0) begin
            check("access_expected", 0, 1);
          end else begin
            a = exp_acc.pop_front();
            check("acc_we", bus.vram_we, a.we);
            check("acc_addr", bus.vram_addr, a.addr);
            if (a.we) check("acc_wdata", bus.vram_wdata, a.wdata);
          end
          a      = '{bus.vram_we, bus.vram_addr, bus.vram_wdata};
          in_acc = 1'b1;
          cnt    = int'($urandom_range(0, max_dly));
        end else begin
          check("acc_stable", {bus.vram_we, bus.vram_addr, bus.vram_wdata},
                              {a.we, a.addr, a.wdata});
        end
        if (cnt == 0) begin
          bus.vram_ack = 1'b1;
          if (bus.vram_we) vmem[bus.vram_addr] = bus.vram_wdata;
          else             bus.vram_rdata = vmem[bus.vram_addr];
          in_acc = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},     bus.instruction_busy, 0);
    check({tag, "_finished"}, bus.instruction_finished, 0);
    check({tag, "_error"},    bus.instruction_error, 0);
    check({tag, "_req"},      bus.vram_req, 0);
    check({tag, "_we"},       bus.vram_we, 0);
    check({tag, "_addr"},     bus.vram_addr, 0);
    check({tag, "_wdata"},    bus.vram_wdata, 0);
    check({tag, "_result_0"}, bus.result_0, 0);
    check({tag, "_result_1"}, bus.result_1, 0);
  endtask

  initial begin : stimulus
    bus.instruction       = 8'h00;
    bus.arg0              = 8'h00;
    bus.arg1              = 8'h00;
    bus.instruction_start = 1'b0;
    for (int i = 0; i < NCELL; i++) begin
      vmem[i]    = 16'h0000;
      exp_mem[i] = 16'h0000;
    end
    reset = 1'b1;
    repeat (2) @(negedge phi2);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Position only: two-cycle latency, no VRAM traffic.
    base = n_acc;
    issue(8'h01, 8'd5, 8'd2, 1, 2);
    check("pos_no_vram", n_acc - base, 0);

    // Write at (5,2) lands at 165, then read back.
    issue(8'h00, 8'h1F, 8'h41, 1, 2);
    issue(8'h03, 8'd5, 8'd2, 1, 2);
    check("get_char", bus.result_0, 8'h41);
    check("get_attr", bus.result_1, 8'h1F);

    // Bottom-right wrap and newline.
    issue(8'h01, 8'd79, 8'd29, 1, 2);
    issue(8'h00, 8'h1F, 8'h42, 1, 2);
    issue(8'h00, 8'h1F, 8'h43, 1, 2);
    issue(8'h01, 8'd10, 8'd3, 1, 2);
    base = n_acc;
    issue(8'h00, 8'h1F, 8'h0A, 1, 2);
    check("newline_no_vram", n_acc - base, 0);
    issue(8'h00, 8'h2E, 8'h44, 1, 2);

    // Range errors.
    issue(8'h01, 8'd80, 8'd0, 1, 2);
    repeat (2) @(negedge phi2);
    check("error_held", bus.instruction_error, 1);
    issue(8'h00, 8'h07, 8'h45, 1, 2);
    base = n_acc;
    issue(8'h03, 8'd0, 8'd30, 1, 2);
    check("get_oob_no_read", n_acc - base, 0);
    issue(8'h01, 8'd3, 8'd3, 1, 2);
    check("error_cleared", bus.instruction_error, 0);

    // Pixel opcode is not ours.
    issue(8'h10, 8'h00, 8'h00, 1, 0);
    repeat (5) @(negedge phi2);
    check("pixel_ignored", bus.instruction_busy, 0);

    // Full clear with random ack delay.
    max_dly = 3;
    base = n_acc;
    issue(8'h02, 8'h07, 8'h00, 1, 0);
    check("clear_count", n_acc - base, NCELL);
    issue(8'h00, 8'h07, 8'h46, 1, 0);
    issue(8'h03, 8'd79, 8'd29, 1, 0);

    // Reset in the middle of a clear.
    issue(8'h02, 8'h07, 8'h00, 0, 0);
    for (int i = 0; i < 20000 && !(bus.vram_req && bus.vram_addr == 12'd1000); i++)
      @(negedge phi2);
    check("clear_reached_1000", bus.vram_req && (bus.vram_addr == 12'd1000), 1);
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    exp_acc.delete();
    exp_res.delete();
    mcol = 0;
    mrow = 0;
    mr0  = 8'h00;
    mr1  = 8'h00;
    repeat (2) @(negedge phi2);
    reset = 1'b0;
    issue(8'h00, 8'h1F, 8'h47, 1, 0);

    repeat (4) @(negedge phi2);
    check("acc_queue_drained", exp_acc.size(), 0);
    check("res_queue_drained", exp_res.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
